// File: rtl/romix_ct_if.sv
// ROMix lane control bundle: start/BlockMix/Integerify inputs, V memory and X-register strobes out.
// Master is the lane top level, slave is the romix_ct sequencer.
interface romix_ct_if #(
  parameter int N_LOG2 = 10
);
  logic              init;
  logic              bm_valid;
  logic [N_LOG2-1:0] j_index;
  logic              load_in;
  logic              bm_init;
  logic              mem_we;
  logic              mem_re;
  logic [N_LOG2-1:0] mem_addr;
  logic              xor_v_en;
  logic              update_x;
  logic              sel_phase;
  logic              busy;
  logic              valid;

  modport master (
    output init, bm_valid, j_index,
    input  load_in, bm_init, mem_we, mem_re, mem_addr,
    input  xor_v_en, update_x, sel_phase, busy, valid
  );

  modport slave (
    input  init, bm_valid, j_index,
    output load_in, bm_init, mem_we, mem_re, mem_addr,
    output xor_v_en, update_x, sel_phase, busy, valid
  );
endinterface

// File: rtl/romix_ct.sv
// romix_ct: sequences one scrypt ROMix lane (fill V with N BlockMix rounds, then N Integerify-indexed mix rounds).
// Latency 1+N(R+2)+N(R+4) cycles to DONE; stalls only in the RUN states until bm_valid, no other backpressure.
module romix_ct #(
  parameter int N_LOG2 = 10
) (
  input logic       clk,
  input logic       reset_n,
  romix_ct_if.slave lane
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    WR_MEM  = 4'd2,
    BM1_RUN = 4'd3,
    BM1_REL = 4'd4,
    RD_ADDR = 4'd5,
    RD_WAIT = 4'd6,
    XOR_V   = 4'd7,
    BM2_RUN = 4'd8,
    BM2_REL = 4'd9,
    DONE    = 4'd10
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [N_LOG2-1:0] i_q;
  logic [N_LOG2-1:0] i_d;
  logic              last_round;

  // N is a power of two, so round N-1 is the all-ones counter value
  assign last_round = (i_q == {N_LOG2{1'b1}});

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      i_q     <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
    end
  end

  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    case (state_q)
      IDLE:    if (lane.init) state_d = LOAD;
      LOAD: begin
        i_d     = '0;
        state_d = WR_MEM;
      end
      WR_MEM:  state_d = BM1_RUN;
      BM1_RUN: if (lane.bm_valid) state_d = BM1_REL;
      BM1_REL: begin
        if (last_round) begin
          i_d     = '0;
          state_d = RD_ADDR;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = WR_MEM;
        end
      end
      RD_ADDR: state_d = RD_WAIT;
      RD_WAIT: state_d = XOR_V;
      XOR_V:   state_d = BM2_RUN;
      BM2_RUN: if (lane.bm_valid) state_d = BM2_REL;
      BM2_REL: begin
        if (last_round) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 1'b1;
          state_d = RD_ADDR;
        end
      end
      DONE:    if (!lane.init) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // j_index only feeds the address while X is frozen (RD_ADDR/RD_WAIT)
  always_comb begin
    lane.load_in   = 1'b0;
    lane.bm_init   = 1'b0;
    lane.mem_we    = 1'b0;
    lane.mem_re    = 1'b0;
    lane.mem_addr  = i_q;
    lane.xor_v_en  = 1'b0;
    lane.update_x  = 1'b0;
    lane.sel_phase = 1'b0;
    lane.busy      = 1'b0;
    lane.valid     = 1'b0;
    case (state_q)
      LOAD: begin
        lane.load_in = 1'b1;
        lane.busy    = 1'b1;
      end
      WR_MEM: begin
        lane.mem_we = 1'b1;
        lane.busy   = 1'b1;
      end
      BM1_RUN: begin
        lane.bm_init = 1'b1;
        lane.busy    = 1'b1;
      end
      BM1_REL: begin
        lane.update_x = 1'b1;
        lane.busy     = 1'b1;
      end
      RD_ADDR: begin
        lane.mem_re    = 1'b1;
        lane.mem_addr  = lane.j_index;
        lane.sel_phase = 1'b1;
        lane.busy      = 1'b1;
      end
      RD_WAIT: begin
        lane.mem_addr  = lane.j_index;
        lane.sel_phase = 1'b1;
        lane.busy      = 1'b1;
      end
      XOR_V: begin
        lane.xor_v_en  = 1'b1;
        lane.sel_phase = 1'b1;
        lane.busy      = 1'b1;
      end
      BM2_RUN: begin
        lane.bm_init   = 1'b1;
        lane.sel_phase = 1'b1;
        lane.busy      = 1'b1;
      end
      BM2_REL: begin
        lane.update_x  = 1'b1;
        lane.sel_phase = 1'b1;
        lane.busy      = 1'b1;
      end
      DONE:    lane.valid = 1'b1;
      default: ;
    endcase
  end

endmodule
